// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the accumulate-sequence controller.
package acc_seq_pkg;

  localparam int ACC_W     = 13;  // datapath accumulator / result width
  localparam int CNT_W     = 5;   // accepted-sample counter width
  localparam int LUT_SCALE = 25;  // datapath multiplies each X by this

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_ACCUM   = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/acc_seq_if.sv
// Handshake bundle between the frame controller and its requester/datapath.
interface acc_seq_if;
  import acc_seq_pkg::*;

  logic             start;
  logic             abort;
  logic             x_valid;
  logic [ACC_W-1:0] acc_val;
  logic             x_ready;
  logic             acc_en;
  logic             acc_clr;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;
  logic             err;

  // Requester + datapath side
  modport master (
    output start, abort, x_valid, acc_val,
    input  x_ready, acc_en, acc_clr, busy, done, result, err
  );

  // Controller side
  modport slave (
    input  start, abort, x_valid, acc_val,
    output x_ready, acc_en, acc_clr, busy, done, result, err
  );
endinterface

// File: rtl/acc_seq_timer.sv
// Idle-cycle watchdog for the ACCUM state: counts consecutive cycles without
// a sample and flags the cycle in which the count reaches TIMEOUT.
module acc_seq_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic Acc_rst2,
  input  logic run,      // controller is in ACCUM
  input  logic idle,     // no sample offered this cycle
  output logic expired
);

  logic [7:0] idle_cnt_reg;

  // Fires on the TIMEOUT-th consecutive idle cycle (count starts at 0).
  assign expired = run && idle && (idle_cnt_reg == 8'(TIMEOUT - 1));

  // Count idle cycles; any accept, exit from ACCUM or expiry restarts it.
  always_ff @(posedge clk or posedge Acc_rst2) begin
    if (Acc_rst2)
      idle_cnt_reg <= '0;
    else if (!run || !idle || expired)
      idle_cnt_reg <= '0;
    else
      idle_cnt_reg <= idle_cnt_reg + 8'd1;
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Frame controller for a multiply-accumulate datapath: clears the datapath,
// accepts N_SAMPLES samples, then captures the sum into result.
// Optional feature: define ACC_SEQ_TIMEOUT_EN to abort a frame after TIMEOUT
// consecutive idle cycles in ACCUM (err pulse); otherwise err is tied low.
module acc_seq_ctrl
  import acc_seq_pkg::*;
#(
  parameter int N_SAMPLES = 4,
  parameter int TIMEOUT   = 15
) (
  input logic      clk,
  input logic      Acc_rst2,
  acc_seq_if.slave bus
);

  if (N_SAMPLES < 1 || N_SAMPLES > 16) begin : g_bad_n_samples
    $error("acc_seq_ctrl: N_SAMPLES out of range 1..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("acc_seq_ctrl: TIMEOUT out of range 1..255");
  end

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ACC_W-1:0] result_reg;
  logic             done_reg;
  logic             x_ready;
  logic             acc_clr;
  logic             timeout;

`ifdef ACC_SEQ_TIMEOUT_EN
  acc_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .Acc_rst2 (Acc_rst2),
    .run      (state_reg == S_ACCUM),
    .idle     (!bus.x_valid),
    .expired  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign bus.x_ready = x_ready;
  assign bus.acc_en  = bus.x_valid & x_ready;
  assign bus.acc_clr = acc_clr;
  assign bus.busy    = (state_reg != S_IDLE);
  assign bus.done    = done_reg;
  assign bus.result  = result_reg;
  assign bus.err     = timeout;

  // State, sample count, captured result and the done pulse.
  always_ff @(posedge clk or posedge Acc_rst2) begin
    if (Acc_rst2) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // CAPTURE is never cut short, so leaving it always completes a frame.
      done_reg  <= (state_reg == S_CAPTURE);
      if (state_reg == S_CAPTURE)
        result_reg <= bus.acc_val;
    end
  end

  // Next-state logic and handshake outputs; abort beats a final accept.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    x_ready    = 1'b0;
    acc_clr    = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (bus.start)
          state_next = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clr    = 1'b1;
        cnt_next   = '0;
        state_next = bus.abort ? S_IDLE : S_ACCUM;
      end
      S_ACCUM: begin
        x_ready = 1'b1;
        if (bus.abort || timeout) begin
          acc_clr    = 1'b1;
          cnt_next   = '0;
          state_next = S_IDLE;
        end else if (bus.x_valid) begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(N_SAMPLES - 1))
            state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // One cycle for acc_val to absorb the last sample.
        cnt_next   = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed self-checking bench for acc_seq_ctrl with a behavioural datapath.
// Exercises the ACC_SEQ_TIMEOUT_EN path when that macro is defined.
module tb_acc_seq_ctrl;
  import acc_seq_pkg::*;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   x_in = 0;
  int   passed = 0;
  int   total = 0;
  logic [ACC_W-1:0] acc_model;

  acc_seq_if bus();

  acc_seq_ctrl #(.N_SAMPLES(4), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .Acc_rst2 (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: clear has priority over accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc_model <= '0;
    else if (bus.acc_clr)
      acc_model <= '0;
    else if (bus.acc_en)
      acc_model <= acc_model + ACC_W'(LUT_SCALE * x_in);
  end
  assign bus.acc_val = acc_model;

  // Apply inputs on the falling edge, then let combinational outputs settle.
  task automatic drive(input logic s, input logic a, input logic v, input int xv);
    @(negedge clk);
    bus.start = s; bus.abort = a; bus.x_valid = v; x_in = xv;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if ({bus.busy, bus.x_ready, bus.acc_en, bus.acc_clr, bus.done, bus.err} !== 6'b0)
      $display("FAIL reset_outputs got %b exp 000000", {bus.busy, bus.x_ready, bus.acc_en, bus.acc_clr, bus.done, bus.err}); else passed++;
    total++; if (bus.result !== 13'd0) $display("FAIL reset_result got %0d exp 0", bus.result); else passed++;
    total++; if (dut.cnt_reg !== 5'd0) $display("FAIL reset_cnt got %0d exp 0", dut.cnt_reg); else passed++;
    drive(1'b1, 1'b0, 1'b1, 3);
    total++; if ({bus.busy, bus.x_ready, bus.acc_en} !== 3'b0)
      $display("FAIL reset_start_held got %b exp 000", {bus.busy, bus.x_ready, bus.acc_en}); else passed++;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0; bus.x_valid = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int xs[4] = '{10, 5, 12, 1};
    drive(1'b1, 1'b0, 1'b0, 0);
    total++; if (bus.busy !== 1'b0) $display("FAIL basic_idle_busy got %b exp 0", bus.busy); else passed++;
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if ({bus.acc_clr, bus.busy, bus.x_ready} !== 3'b110)
      $display("FAIL basic_clear got %b exp 110", {bus.acc_clr, bus.busy, bus.x_ready}); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, xs[i]);
      total++; if ({bus.x_ready, bus.acc_en} !== 2'b11)
        $display("FAIL basic_accept%0d got %b exp 11", i, {bus.x_ready, bus.acc_en}); else passed++;
    end
    drive(1'b0, 1'b0, 0, 0);
    total++; if ({bus.x_ready, bus.busy, bus.done} !== 3'b010)
      $display("FAIL basic_capture got %b exp 010", {bus.x_ready, bus.busy, bus.done}); else passed++;
    total++; if (bus.acc_val !== 13'd700) $display("FAIL basic_acc got %0d exp 700", bus.acc_val); else passed++;
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if ({bus.done, bus.busy} !== 2'b10) $display("FAIL basic_done got %b exp 10", {bus.done, bus.busy}); else passed++;
    total++; if (bus.result !== 13'd700) $display("FAIL basic_result got %0d exp 700", bus.result); else passed++;
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if (bus.done !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", bus.done); else passed++;
    total++; if (bus.result !== 13'd700) $display("FAIL basic_result_hold got %0d exp 700", bus.result); else passed++;
    $display("test_basic done");
  endtask

  task automatic test_abort();
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b1, 3);
    drive(1'b0, 1'b0, 1'b1, 4);
    drive(1'b0, 1'b1, 1'b0, 0);
    total++; if ({bus.acc_clr, bus.x_ready} !== 2'b11)
      $display("FAIL abort_clr got %b exp 11", {bus.acc_clr, bus.x_ready}); else passed++;
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if ({bus.busy, bus.x_ready} !== 2'b00) $display("FAIL abort_idle got %b exp 00", {bus.busy, bus.x_ready}); else passed++;
    total++; if (bus.acc_val !== 13'd0) $display("FAIL abort_acc got %0d exp 0", bus.acc_val); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 0);
      total++; if (bus.done !== 1'b0 || bus.result !== 13'd700)
        $display("FAIL abort_nodone%0d got done=%b result=%0d exp done=0 result=700", i, bus.done, bus.result); else passed++;
    end
    // Abort coinciding with the final accept.
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 2);
    drive(1'b0, 1'b1, 1'b1, 2);
    total++; if ({bus.acc_en, bus.acc_clr} !== 2'b11)
      $display("FAIL abort_final_accept got %b exp 11", {bus.acc_en, bus.acc_clr}); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 0);
      total++; if ({bus.busy, bus.done} !== 2'b00 || bus.result !== 13'd700)
        $display("FAIL abort_final%0d got busy_done=%b result=%0d exp 00 700", i, {bus.busy, bus.done}, bus.result); else passed++;
    end
    $display("test_abort done");
  endtask

  task automatic test_gaps();
    int xs[4] = '{13, 7, 9, 2};
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 1'b0, 1'b0, 0);
          total++; if ({bus.x_ready, bus.acc_en} !== 2'b10 || dut.cnt_reg !== 5'(i))
            $display("FAIL gaps_hold%0d_%0d got rdy_en=%b cnt=%0d exp 10 %0d", i, g, {bus.x_ready, bus.acc_en}, dut.cnt_reg, i); else passed++;
        end
      end
      drive(1'b0, 1'b0, 1'b1, xs[i]);
      total++; if (bus.acc_en !== 1'b1) $display("FAIL gaps_accept%0d got %b exp 1", i, bus.acc_en); else passed++;
    end
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if (bus.done !== 1'b1 || bus.result !== 13'd775)
      $display("FAIL gaps_result got done=%b result=%0d exp done=1 result=775", bus.done, bus.result); else passed++;
    $display("test_gaps done");
  endtask

  task automatic test_reset_mid();
    int xs[4] = '{11, 5, 4, 2};
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b1, 6);
    drive(1'b0, 1'b0, 1'b1, 6);
    @(negedge clk);
    bus.x_valid = 1'b1; x_in = 6; rst = 1'b1;
    #1;
    total++; if ({bus.busy, bus.x_ready, bus.acc_en, bus.acc_clr, bus.done, bus.err} !== 6'b0 || bus.result !== 13'd0)
      $display("FAIL rstmid_outputs got %b result=%0d exp 000000 0", {bus.busy, bus.x_ready, bus.acc_en, bus.acc_clr, bus.done, bus.err}, bus.result); else passed++;
    @(negedge clk);
    rst = 1'b0; bus.x_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 0);
      total++; if ({bus.busy, bus.done} !== 2'b00)
        $display("FAIL rstmid_nodone%0d got %b exp 00", i, {bus.busy, bus.done}); else passed++;
    end
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if (bus.acc_clr !== 1'b1) $display("FAIL rstmid_clear got %b exp 1", bus.acc_clr); else passed++;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, xs[i]);
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if (bus.done !== 1'b1 || bus.result !== 13'd550)
      $display("FAIL rstmid_result got done=%b result=%0d exp done=1 result=550", bus.done, bus.result); else passed++;
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    int xs[4] = '{1, 2, 3, 4};
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) drive(i == 1, 1'b0, 1'b1, xs[i]);
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    total++; if (bus.done !== 1'b1 || bus.result !== 13'd250)
      $display("FAIL b2b_first got done=%b result=%0d exp done=1 result=250", bus.done, bus.result); else passed++;
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if ({bus.acc_clr, bus.busy} !== 2'b11) $display("FAIL b2b_clear got %b exp 11", {bus.acc_clr, bus.busy}); else passed++;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 4);
    // CAPTURE: abort and start both present and both ignored.
    drive(1'b1, 1'b1, 1'b0, 0);
    total++; if ({bus.busy, bus.acc_clr} !== 2'b10) $display("FAIL b2b_capture_abort got %b exp 10", {bus.busy, bus.acc_clr}); else passed++;
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if (bus.done !== 1'b1 || bus.result !== 13'd400)
      $display("FAIL b2b_second got done=%b result=%0d exp done=1 result=400", bus.done, bus.result); else passed++;
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL b2b_not_queued got %b exp 00", {bus.busy, bus.done}); else passed++;
    $display("test_back_to_back done");
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b1, 8);
    for (int k = 1; k < TMO; k++) begin
      drive(1'b0, 1'b0, 1'b0, 0);
      total++; if ({bus.err, bus.acc_clr, bus.x_ready} !== 3'b001)
        $display("FAIL tmo_wait%0d got %b exp 001", k, {bus.err, bus.acc_clr, bus.x_ready}); else passed++;
    end
`ifdef ACC_SEQ_TIMEOUT_EN
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if ({bus.err, bus.acc_clr} !== 2'b11) $display("FAIL tmo_fire got %b exp 11", {bus.err, bus.acc_clr}); else passed++;
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if ({bus.busy, bus.err} !== 2'b00) $display("FAIL tmo_idle got %b exp 00", {bus.busy, bus.err}); else passed++;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 0);
      total++; if (bus.done !== 1'b0 || bus.result !== 13'd400)
        $display("FAIL tmo_nodone%0d got done=%b result=%0d exp done=0 result=400", i, bus.done, bus.result); else passed++;
    end
`else
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 1'b0, 0);
      total++; if ({bus.err, bus.busy} !== 2'b01)
        $display("FAIL tmo_off_wait%0d got %b exp 01", k, {bus.err, bus.busy}); else passed++;
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 8);
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    total++; if (bus.done !== 1'b1 || bus.result !== 13'd800)
      $display("FAIL tmo_off_result got done=%b result=%0d exp done=1 result=800", bus.done, bus.result); else passed++;
`endif
    $display("test_timeout done");
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.x_valid = 1'b0;
    test_reset();
    test_basic();
    test_abort();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
